ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester round-robin arbiter that shares the single backing `ram` between two cache controllers, for example an instruction-side and a data-side cache. It accepts held-level requests from each side, serialises them onto one RAM command interface, and waits for the RAM's level `response` to drop and rise again. It then returns a one-cycle acknowledge and registered read data to the owning requester. It sits between the cache instances and the `ram` instance.

## Interface
- `TIMEOUT`, default 255: RAM watchdog limit in clocks; used only when the watchdog is compiled in.
- `TO_W`, default 8: watchdog counter width; must satisfy `TIMEOUT < 2**TO_W`.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req0`, `req1` input 1: request level; held high by the requester until its ack.
- `wr0`, `wr1` input 1: 1 = write, 0 = read; stable while req is high.
- `addr0`, `addr1` input 32: word address; stable while req is high.
- `wdata0`, `wdata1` input 32: write data; stable while req is high.
- `ack0`, `ack1` output 1: one-cycle completion pulse to the owning port.
- `rdata` output 32: shared read data; valid while ack is high, held afterwards.
- `grant` output 1: index of the port owning the current or last transaction.
- `busy` output 1: high in every state except IDLE.
- `err` output 1: one-cycle pulse with ack on a watchdog abort.
- `ram_req` output 1: one-cycle command strobe to the RAM.
- `ram_wr` output 1: RAM write enable, registered per transaction.
- `ram_addr` output 32: RAM address, registered per transaction.
- `ram_wdata` output 32: RAM write data, registered per transaction.
- `ram_ack` input 1: RAM `response` level; goes low while busy and high when done.
- `ram_rdata` input 32: RAM read output.

## Operation
- **States.** IDLE → ISSUE → BUSY → WAIT → DONE → IDLE.
- **IDLE, arbitration.**
  - If exactly one req is high, that port wins.
  - If both are high, the port not equal to `last` wins.
  - The winner's wr, addr and wdata are latched into the `ram_*` registers, `grant` = winner, `last` = winner, and the state goes to ISSUE.
- **ISSUE.** `ram_req` = 1 for exactly this cycle. Next state is BUSY.
- **BUSY.** Wait until `ram_ack` is sampled 0, then go to WAIT. This rejects a stale high `response` left over from the previous operation.
- **WAIT.** Wait until `ram_ack` is sampled 1, then go to DONE. On that edge, a read captures `ram_rdata` into `rdata`; a write leaves `rdata` unchanged.
- **DONE.** `ack[grant]` = 1 for one cycle. Next state is IDLE.
- **Requests during a transaction.** Any req arriving while not in IDLE waits; the arbiter samples requests only in IDLE.
- **Requester rule.** A requester drops req on the edge where it sees ack. If req is still high in IDLE, it is treated as a new request.
- **Fairness.** Under continuous requests from both ports, grants alternate strictly 0,1,0,1.
- **Reset values** (async, any state):
  - state = IDLE, `last` = 1 (so port 0 wins the first tie).
  - `grant`, `busy`, `err`, `ack0`, `ack1`, `ram_req`, `ram_wr` = 0.
  - `ram_addr`, `ram_wdata`, `rdata` = 0.
- **Reset mid-transaction.** The transaction is dropped with no ack. `ram_req` goes low immediately.

## Timing
- **Request to ack.** Requests are sampled at edge E0 in IDLE.
  - ISSUE occupies the cycle after E0.
  - The earliest BUSY→WAIT transition is at E2, and the earliest WAIT→DONE transition is at E3.
  - ack is high during E3–E4, so the minimum latency is 4 clocks.
- **Back-to-back.** The next transaction's ISSUE begins 2 cycles after ack (the DONE and IDLE cycles).
- **Output timing.** All outputs are registered. `ram_*` command fields are stable from ISSUE through DONE.

## Configuration
- **Macro `RAM_ARB_WATCHDOG_EN`.**
- **Defined:** a `TO_W`-bit counter clears in ISSUE and increments each cycle in BUSY and WAIT.
  - On reaching `TIMEOUT`, the arbiter goes to DONE.
  - In that DONE cycle, ack and `err` pulse together and `rdata` is forced to 0.
  - A normal completion on the same edge as the timeout takes priority: completion wins, `err` = 0.
- **Undefined:** BUSY and WAIT wait indefinitely, `err` is tied 0, and the counter does not exist.

## Test plan
- **Single read.**
  - Stimulus: reset, then `req0`=1, `wr0`=0, `addr0`=0x10. The RAM model drops `ram_ack` 1 cycle after `ram_req` and raises it 3 cycles later with `ram_rdata`=0xCAFE0001.
  - Required: `ram_req` pulses once with `ram_addr`=0x10; `ack0` pulses once with `rdata`=0xCAFE0001; `ack1` stays 0.
- **Tie after reset.**
  - Stimulus: `req0` and `req1` both rise on the same cycle.
  - Required: port 0 is served first (`grant`=0), then port 1; `ack0` precedes `ack1`.
- **Continuous contention.**
  - Stimulus: both ports re-request immediately after every ack, for 6 transactions.
  - Required: `grant` sequence is 0,1,0,1,0,1 and ack pulses are never simultaneous.
- **Write then stale ack.**
  - Stimulus: `req1` write with `addr1`=0x20 and `wdata1`=0x55 while `ram_ack` is held 1 for 2 cycles after ISSUE.
  - Required: no ack until `ram_ack` has gone 0 and then 1; `ram_wr`=1 and `ram_wdata`=0x55; `rdata` unchanged.
- **Reset mid-WAIT.**
  - Stimulus: assert `rst_n`=0 during WAIT.
  - Required: all outputs go to their reset values immediately and no ack is issued; after release, a new `req0` completes normally.
- **Watchdog** (with `RAM_ARB_WATCHDOG_EN`, `TIMEOUT`=16).
  - Stimulus: `ram_ack` stuck at 0.
  - Required: `ack0` and `err` pulse together with `rdata`=0; a subsequent request succeeds.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single level-handshake RAM.
// Optional RAM watchdog abort is compiled in with RAM_ARB_WATCHDOG_EN.
module ram_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        grant,
    output logic        busy,
    output logic        err,
    output logic        ram_req,
    output logic        ram_wr,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_WAIT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        grant_q, grant_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        ram_req_q, ram_req_d;
    logic        ram_wr_q, ram_wr_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic any_req;
    logic win;
    logic to_hit;

    assign any_req = req0 | req1;
    // On a tie the port that did not own the last transaction wins.
    assign win     = (req0 & req1) ? ~last_q : req1;

`ifdef RAM_ARB_WATCHDOG_EN
    logic [TO_W-1:0] cnt_q, cnt_d;

    assign to_hit = (cnt_q >= TO_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == S_BUSY || state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign to_hit     = 1'b0;
    assign unused_cfg = ^{TIMEOUT, TO_W};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_BUSY;
            S_BUSY: begin
                if (to_hit) state_d = S_DONE;
                else if (!ram_ack) state_d = S_WAIT;
            end
            S_WAIT:  if (ram_ack || to_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_d      = last_q;
        grant_d     = grant_q;
        ram_wr_d    = ram_wr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
        ram_req_d   = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err_d       = 1'b0;
        busy_d      = (state_d != S_IDLE);
        if (state_q == S_IDLE && any_req) begin
            grant_d     = win;
            last_d      = win;
            ram_req_d   = 1'b1;
            ram_wr_d    = win ? wr1 : wr0;
            ram_addr_d  = win ? addr1 : addr0;
            ram_wdata_d = win ? wdata1 : wdata0;
        end
        if (state_q != S_DONE && state_d == S_DONE) begin
            ack0_d = ~grant_q;
            ack1_d = grant_q;
            // A real completion outranks a timeout on the same edge.
            if (state_q == S_WAIT && ram_ack) begin
                if (!ram_wr_q) rdata_d = ram_rdata;
            end else begin
                err_d   = 1'b1;
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            last_q      <= last_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            ram_req_q   <= ram_req_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign ram_req   = ram_req_q;
    assign ram_wr    = ram_wr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a level-handshake RAM model.
// The watchdog case runs only when RAM_ARB_WATCHDOG_EN is defined.
module tb_ram_arbiter;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        wr0 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, grant, busy, err;
    logic [31:0] rdata;
    logic        ram_req, ram_wr;
    logic [31:0] ram_addr, ram_wdata;
    logic        ram_ack = 1'b1;
    logic [31:0] ram_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int hold     = 1;
    int lo       = 3;
    bit stuck    = 1'b0;

    cmd_t        cmd_q[$];
    ack_t        ack_q[$];
    logic [31:0] exp_rd = '0;

    ram_arbiter #(.TIMEOUT(16), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .grant(grant),
        .busy(busy), .err(err),
        .ram_req(ram_req), .ram_wr(ram_wr),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return 32'hCAFE0000 | (a >> 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic exp_cmd(input logic w, input logic [31:0] a,
                           input logic [31:0] d);
        cmd_t c;
        c.wr = w; c.addr = a; c.wdata = d;
        cmd_q.push_back(c);
    endtask

    task automatic exp_ack(input logic p, input logic w,
                           input logic [31:0] a, input logic e);
        ack_t k;
        if (e) exp_rd = '0;
        else if (!w) exp_rd = rd_fn(a);
        k.port = p; k.rdata = exp_rd; k.err = e;
        ack_q.push_back(k);
    endtask

    task automatic exp_txn(input logic p, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        exp_cmd(w, a, d);
        exp_ack(p, w, a, 1'b0);
    endtask

    task automatic do_req(input logic p, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat);
        @(negedge clk);
        if (p) begin req1 = 1; wr1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; wr0 = w; addr0 = a; wdata0 = d; end
        lat = 0;
        while (!(p ? ack1 : ack0) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) check("ack_seen", 32'(p ? ack1 : ack0), 32'd1);
        if (p) req1 = 0; else req0 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        exp_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // RAM model: drop response some cycles after the strobe, raise it later.
    initial begin
        forever begin
            @(negedge clk);
            if (ram_req === 1'b1) begin
                repeat (hold) @(negedge clk);
                ram_ack = 1'b0;
                while (stuck) @(negedge clk);
                repeat (lo) @(negedge clk);
                ram_rdata = rd_fn(ram_addr);
                ram_ack   = 1'b1;
            end
        end
    end

    // Monitor: pop expectations whenever the DUT strobes the RAM or acks.
    initial begin
        cmd_t c;
        ack_t k;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ram_req) begin
                    check("cmd_exp", 32'(cmd_q.size() > 0), 32'd1);
                    if (cmd_q.size() > 0) begin
                        c = cmd_q.pop_front();
                        check("ram_wr", 32'(ram_wr), 32'(c.wr));
                        check("ram_addr", ram_addr, c.addr);
                        check("ram_wdata", ram_wdata, c.wdata);
                    end
                end
                if (err && !(ack0 || ack1)) check("err_no_ack", 32'(err), 32'd0);
                if (ack0 || ack1) begin
                    check("ack_excl", 32'(ack0 & ack1), 32'd0);
                    check("ack_exp", 32'(ack_q.size() > 0), 32'd1);
                    if (ack_q.size() > 0) begin
                        k = ack_q.pop_front();
                        check("ack_port", 32'(ack1), 32'(k.port));
                        check("grant", 32'(grant), 32'(k.port));
                        check("rdata", rdata, k.rdata);
                        check("err", 32'(err), 32'(k.err));
                    end
                end
            end
        end
    end

    initial begin
        int lat, lat0, lat1, n;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'({ack0, ack1, err, ram_req, ram_wr}), 32'd0);
        check("rst_addr", ram_addr, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        exp_txn(1'b0, 1'b0, 32'h10, 32'h0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, lat);
        check("lat_read", 32'(lat), 32'd6);
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        do_reset();
        exp_txn(1'b0, 1'b0, 32'h40, 32'h0);
        exp_txn(1'b1, 1'b0, 32'h50, 32'h0);
        fork
            do_req(1'b0, 1'b0, 32'h40, 32'h0, lat0);
            do_req(1'b1, 1'b0, 32'h50, 32'h0, lat1);
        join
        check("tie_order", 32'(lat0 < lat1), 32'd1);
        repeat (6) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            exp_txn(1'b0, 1'b0, 32'h100 + 32'(i * 16), 32'h0);
            exp_txn(1'b1, 1'b0, 32'h200 + 32'(i * 16), 32'h0);
        end
        fork
            for (int i = 0; i < 3; i++) begin
                do_req(1'b0, 1'b0, 32'h100 + 32'(i * 16), 32'h0, lat0);
            end
            for (int j = 0; j < 3; j++) begin
                do_req(1'b1, 1'b0, 32'h200 + 32'(j * 16), 32'h0, lat1);
            end
        join
        repeat (6) @(negedge clk);

        hold = 3;
        exp_txn(1'b1, 1'b1, 32'h20, 32'h55);
        do_req(1'b1, 1'b1, 32'h20, 32'h55, lat);
        check("lat_stale", 32'(lat), 32'd8);
        hold = 1;
        repeat (6) @(negedge clk);

        exp_cmd(1'b0, 32'h60, 32'h0);
        @(negedge clk);
        req0 = 1; wr0 = 0; addr0 = 32'h60; wdata0 = 32'h0;
        n = 0;
        while (!ram_req && n < 50) begin @(negedge clk); n++; end
        while (ram_ack && n < 50) begin @(negedge clk); n++; end
        check("mid_wait_reached", 32'(n < 50), 32'd1);
        @(negedge clk);
        rst_n  = 1'b0;
        exp_rd = '0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ramreq", 32'(ram_req), 32'd0);
        check("mrst_addr", ram_addr, 32'd0);
        check("mrst_ack", 32'({ack0, ack1, err}), 32'd0);
        check("mrst_rdata", rdata, 32'd0);
        req0 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        exp_txn(1'b0, 1'b0, 32'h70, 32'h0);
        do_req(1'b0, 1'b0, 32'h70, 32'h0, lat);
        repeat (6) @(negedge clk);

`ifdef RAM_ARB_WATCHDOG_EN
        stuck = 1'b1;
        exp_cmd(1'b0, 32'h80, 32'h0);
        exp_ack(1'b0, 1'b0, 32'h80, 1'b1);
        do_req(1'b0, 1'b0, 32'h80, 32'h0, lat);
        stuck = 1'b0;
        repeat (8) @(negedge clk);
        exp_txn(1'b0, 1'b0, 32'h90, 32'h0);
        do_req(1'b0, 1'b0, 32'h90, 32'h0, lat);
        repeat (6) @(negedge clk);
`endif

        check("cmd_left", 32'(cmd_q.size()), 32'd0);
        check("ack_left", 32'(ack_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
